// File: rtl/align_job_arbiter.sv
// align_job_arbiter: round-robin front end for one shared alignment core.
// Launches jobs, counts traceback steps, returns tagged or timed-out responses.
module align_job_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int SEQ_LENGTH     = 32,
  parameter int LETTER_W       = 2,
  parameter int COORD_W        = 5,
  parameter int LEN_W          = 7,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [NUM_REQ-1:0]                              req_valid,
  output logic [NUM_REQ-1:0]                              req_ready,
  input  logic [NUM_REQ-1:0][SEQ_LENGTH*LETTER_W-1:0]     req_query,
  input  logic [NUM_REQ-1:0][SEQ_LENGTH*LETTER_W-1:0]     req_database,
  output logic                                            core_start,
  output logic [SEQ_LENGTH*LETTER_W-1:0]                  core_query,
  output logic [SEQ_LENGTH*LETTER_W-1:0]                  core_database,
  input  logic                                            core_ready,
  input  logic                                            core_output_valid,
  input  logic                                            core_finished,
  input  logic [COORD_W-1:0]                              trace_row,
  input  logic [COORD_W-1:0]                              trace_col,
  output logic [NUM_REQ-1:0]                              rsp_valid,
  input  logic [NUM_REQ-1:0]                              rsp_ready,
  output logic [LEN_W-1:0]                                rsp_len,
  output logic [COORD_W-1:0]                              rsp_row,
  output logic [COORD_W-1:0]                              rsp_col,
  output logic                                            rsp_err,
  output logic                                            busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW = SEQ_LENGTH * LETTER_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_TRACE,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [IW-1:0]      r_rr;
  logic [IW-1:0]      r_owner;
  logic [DW-1:0]      r_query;
  logic [DW-1:0]      r_database;
  logic [TMO_W-1:0]   r_wd;
  logic [LEN_W-1:0]   r_len;
  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] r_col;
  logic               r_err;

  logic               w_gnt_any;
  logic [IW-1:0]      w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [NUM_REQ-1:0] w_own_oh;
  logic [IW-1:0]      w_rr_next;
  logic               w_idle;
  logic               w_resp;
  logic               w_accept;
  logic               w_rsp_done;
  logic [TMO_W-1:0]   w_wd_inc;
  logic               w_tmo;
  logic [LEN_W-1:0]   w_len_inc;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    int idx;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_rr) + k) % NUM_REQ;
      if (!w_gnt_any && req_valid[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IW'(idx);
      end
    end
  end

  assign w_gnt_oh   = NUM_REQ'(1) << w_gnt_idx;
  assign w_own_oh   = NUM_REQ'(1) << r_owner;
  assign w_rr_next  = (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IW'(1);
  assign w_idle     = (r_state == S_IDLE);
  assign w_resp     = (r_state == S_RESP);
  assign w_wd_inc   = r_wd + TMO_W'(1);
  assign w_tmo      = (w_wd_inc == TMO_W'(TIMEOUT_CYCLES));
  assign w_len_inc  = (r_len == '1) ? r_len : r_len + LEN_W'(1);

  assign req_ready  = (rst_n && w_idle && w_gnt_any) ? w_gnt_oh : '0;
  assign w_accept   = |(req_valid & req_ready);
  // A launch that coincides with the watchdog firing is suppressed:
  // the job is already being abandoned.
  assign core_start = (r_state == S_LAUNCH) && core_ready && !w_tmo;
  assign w_rsp_done = w_resp && rsp_ready[r_owner];

  assign core_query    = r_query;
  assign core_database = r_database;
  assign rsp_valid     = w_resp ? w_own_oh : '0;
  assign rsp_len       = w_resp ? r_len : '0;
  assign rsp_row       = w_resp ? r_row : '0;
  assign rsp_col       = w_resp ? r_col : '0;
  assign rsp_err       = w_resp && r_err;
  assign busy          = !w_idle;

  // Job FSM: accept, launch, observe traceback, respond; watchdog overrides.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_owner    <= '0;
      r_query    <= '0;
      r_database <= '0;
      r_wd       <= '0;
      r_len      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_query    <= req_query[w_gnt_idx];
            r_database <= req_database[w_gnt_idx];
            r_owner    <= w_gnt_idx;
            r_rr       <= w_rr_next;
            r_wd       <= '0;
            r_len      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_err      <= 1'b0;
            r_state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_wd <= w_wd_inc;
          if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else if (core_ready) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_wd <= w_wd_inc;
          if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else if (core_output_valid) begin
            r_row   <= trace_row;
            r_col   <= trace_col;
            r_len   <= LEN_W'(1);
            r_state <= core_finished ? S_RESP : S_TRACE;
          end else if (core_finished) begin
            r_state <= S_RESP;
          end
        end
        S_TRACE: begin
          r_wd <= w_wd_inc;
          if (core_output_valid) r_len <= w_len_inc;
          if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else if (core_finished) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_rsp_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_align_job_arbiter.sv
// tb_align_job_arbiter: table of jobs driven through a behavioural core,
// expected responses queued at accept and compared on rsp_valid.
module tb_align_job_arbiter;

  localparam int NR = 2;
  localparam int DW = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NR-1:0]      req_valid = '0;
  logic [NR-1:0]      req_ready;
  logic [NR-1:0][DW-1:0] req_query = '0;
  logic [NR-1:0][DW-1:0] req_database = '0;
  logic               core_start;
  logic [DW-1:0]      core_query;
  logic [DW-1:0]      core_database;
  logic               core_ready = 1'b0;
  logic               core_output_valid = 1'b0;
  logic               core_finished = 1'b0;
  logic [4:0]         trace_row = '0;
  logic [4:0]         trace_col = '0;
  logic [NR-1:0]      rsp_valid;
  logic [NR-1:0]      rsp_ready = '0;
  logic [6:0]         rsp_len;
  logic [4:0]         rsp_row;
  logic [4:0]         rsp_col;
  logic               rsp_err;
  logic               busy;

  always #5 clk = ~clk;

  align_job_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_query(req_query), .req_database(req_database),
    .core_start(core_start), .core_query(core_query),
    .core_database(core_database), .core_ready(core_ready),
    .core_output_valid(core_output_valid),
    .core_finished(core_finished),
    .trace_row(trace_row), .trace_col(trace_col),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_len(rsp_len), .rsp_row(rsp_row), .rsp_col(rsp_col),
    .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic [1:0] req;
    int         delay;
    int         steps;
    logic [4:0] row;
    logic [4:0] col;
    bit         fin;
    int         hold;
    logic [1:0] e_gnt;
    logic [6:0] e_len;
    logic [4:0] e_row;
    logic [4:0] e_col;
    logic       e_err;
  } vec_t;

  typedef struct {
    logic [1:0]  vld;
    logic [6:0]  len;
    logic [4:0]  row;
    logic [4:0]  col;
    logic        err;
    logic [63:0] q;
    logic [63:0] d;
  } exp_t;

  exp_t sb[$];
  vec_t vt[9];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Continuous protocol invariants.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("rdy_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      chk("rdy_while_busy", 64'(busy && (req_ready != '0)), 64'd0);
      chk("rsp_onehot", 64'($countones(rsp_valid) <= 1), 64'd1);
      chk("start_idle", 64'(core_start && !busy), 64'd0);
    end
  end

  task automatic run_job(input vec_t v);
    logic [63:0] qa[2];
    logic [63:0] da[2];
    int          w;
    int          n;
    int          acc;
    exp_t        e;
    exp_t        got;
    for (int i = 0; i < NR; i++) begin
      qa[i] = {$urandom, $urandom};
      da[i] = {$urandom, $urandom};
      req_query[i]    = qa[i];
      req_database[i] = da[i];
    end
    w = v.e_gnt[1] ? 1 : 0;
    @(negedge clk);
    req_valid  = v.req;
    core_ready = (v.delay == 0);
    #1 chk("grant", 64'(req_ready), 64'(v.e_gnt));
    e.vld = v.e_gnt; e.len = v.e_len; e.row = v.e_row;
    e.col = v.e_col; e.err = v.e_err; e.q = qa[w]; e.d = da[w];
    sb.push_back(e);
    @(negedge clk);
    #1 acc = cyc;
    chk("latched_query", core_query, qa[w]);
    chk("latched_db", core_database, da[w]);
    chk("busy", 64'(busy), 64'd1);
    for (int i = 0; i < v.delay; i++) begin
      chk("start_held", 64'(core_start), 64'd0);
      @(negedge clk);
      if (i == v.delay - 1) core_ready = 1'b1;
      #1;
    end
    chk("core_start", 64'(core_start), 64'd1);
    @(negedge clk);
    core_ready = 1'b0;
    for (int s = 0; s < v.steps; s++) begin
      core_output_valid = 1'b1;
      trace_row = (s == 0) ? v.row : 5'($urandom);
      trace_col = (s == 0) ? v.col : 5'($urandom);
      @(negedge clk);
    end
    core_output_valid = 1'b0;
    core_finished     = v.fin;
    @(negedge clk);
    core_finished = 1'b0;
    if (v.fin) core_ready = 1'b1;
    n = 0;
    #1;
    while (rsp_valid == '0 && n < 400) begin
      @(negedge clk);
      #1 n++;
    end
    if (rsp_valid == '0) begin
      chk("rsp_wait_expired", 64'd0, 64'd1);
      req_valid = '0;
      return;
    end
    if (v.e_err) chk("tmo_cycles", 64'(cyc - acc), 64'd255);
    if (sb.size() == 0) begin
      chk("sb_empty_on_rsp", 64'd0, 64'd1);
      return;
    end
    got = sb.pop_front();
    chk("rsp_valid", 64'(rsp_valid), 64'(got.vld));
    chk("rsp_len", 64'(rsp_len), 64'(got.len));
    chk("rsp_row", 64'(rsp_row), 64'(got.row));
    chk("rsp_col", 64'(rsp_col), 64'(got.col));
    chk("rsp_err", 64'(rsp_err), 64'(got.err));
    chk("query_stable", core_query, got.q);
    chk("db_stable", core_database, got.d);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      rsp_ready = ~got.vld;
      #1;
      chk("bp_valid", 64'(rsp_valid), 64'(got.vld));
      chk("bp_len", 64'(rsp_len), 64'(got.len));
      chk("bp_row", 64'(rsp_row), 64'(got.row));
      chk("bp_col", 64'(rsp_col), 64'(got.col));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    rsp_ready = got.vld;
    req_valid = '0;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    chk("rsp_clear", 64'({rsp_valid, rsp_len, rsp_row, rsp_col, rsp_err}), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic idle_ignore();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      core_finished     = 1'b1;
      core_output_valid = 1'b1;
      #1;
      chk("idle_ignore_busy", 64'(busy), 64'd0);
      chk("idle_ignore_rsp", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    core_finished     = 1'b0;
    core_output_valid = 1'b0;
    #1 chk("idle_ignore_end", 64'(busy), 64'd0);
  endtask

  task automatic reset_mid_trace();
    vec_t vr;
    @(negedge clk);
    req_valid  = 2'b01;
    core_ready = 1'b1;
    #1 chk("rst_grant", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = '0;
    #1 chk("rst_start", 64'(core_start), 64'd1);
    @(negedge clk);
    core_ready        = 1'b0;
    core_output_valid = 1'b1;
    trace_row         = 5'd5;
    trace_col         = 5'd6;
    @(negedge clk);
    @(negedge clk);
    core_output_valid = 1'b0;
    rst_n             = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_outs", 64'({req_ready, core_start, rsp_valid, rsp_len,
                         rsp_row, rsp_col, rsp_err, busy}), 64'd0);
    chk("rst_query", core_query, 64'd0);
    chk("rst_db", core_database, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    vr = '{2'b11, 0, 2, 5'd3, 5'd4, 1'b1, 0, 2'b01, 7'd2, 5'd3, 5'd4, 1'b0};
    run_job(vr);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'b11, 0, 3, 5'd7,  5'd2,  1'b1, 0,  2'b01, 7'd3, 5'd7,  5'd2,  1'b0};
    vt[1] = '{2'b11, 0, 1, 5'd0,  5'd31, 1'b1, 0,  2'b10, 7'd1, 5'd0,  5'd31, 1'b0};
    vt[2] = '{2'b11, 0, 2, 5'd16, 5'd16, 1'b1, 0,  2'b01, 7'd2, 5'd16, 5'd16, 1'b0};
    vt[3] = '{2'b11, 0, 4, 5'd1,  5'd1,  1'b1, 0,  2'b10, 7'd4, 5'd1,  5'd1,  1'b0};
    vt[4] = '{2'b01, 0, 5, 5'd30, 5'd31, 1'b1, 0,  2'b01, 7'd5, 5'd30, 5'd31, 1'b0};
    vt[5] = '{2'b01, 0, 4, 5'd12, 5'd5,  1'b1, 10, 2'b01, 7'd4, 5'd12, 5'd5,  1'b0};
    vt[6] = '{2'b01, 7, 0, 5'd0,  5'd0,  1'b1, 0,  2'b01, 7'd0, 5'd0,  5'd0,  1'b0};
    vt[7] = '{2'b10, 0, 2, 5'd9,  5'd3,  1'b0, 0,  2'b10, 7'd2, 5'd9,  5'd3,  1'b1};
    vt[8] = '{2'b10, 0, 1, 5'd31, 5'd0,  1'b1, 0,  2'b10, 7'd1, 5'd31, 5'd0,  1'b0};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 64'({req_ready, core_start, rsp_valid, rsp_len,
                           rsp_row, rsp_col, rsp_err, busy}), 64'd0);
    chk("reset_query", core_query, 64'd0);
    chk("reset_db", core_database, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int j = 0; j < 9; j++) begin
      run_job(vt[j]);
      if (vt[j].e_err) idle_ignore();
    end

    reset_mid_trace();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
